bellman_ford_engine: RTL and testbench
======================================

# bellman_ford_engine

Parametrised Bellman-Ford relaxation engine for the arbitrage graph. It initialises the vertex table from a source vertex, then sweeps the dense adjacency matrix pass by pass. It stops early once a pass makes no relaxation, and optionally runs an extra detection pass that flags a negative cycle, which is an arbitrage opportunity. It sits between the host-loaded adjacency RAM and the dual-port vertex RAM, which the host reads back once `done` is asserted.

## Interface
- `NODES`, 16: vertex count, at least 2.
- `WEIGHT_W`, 32: signed edge/distance width.
- `PRED_W`, $clog2(NODES): vertex index width.
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a run. Ignored while `busy`.
- `src` in PRED_W: source vertex, sampled on `start`.
- `adjmat_row_addr`, `adjmat_col_addr` out PRED_W: edge (i→j) address.
- `adjmat_q` in WEIGHT_W: signed edge weight. 0 means no edge.
- `vertmat_addr_a`, `vertmat_addr_b` out PRED_W: vertex RAM addresses. Port A is source i, port B is destination j.
- `vertmat_q_a`, `vertmat_q_b` in PRED_W+WEIGHT_W: vertex words {pred, dist}.
- `vertmat_data_a`, `vertmat_data_b` out PRED_W+WEIGHT_W: write data.
- `vertmat_we_a`, `vertmat_we_b` out 1: write enables.
- `busy` out 1: a run is in progress.
- `done` out 1: level signal held from the end of a run until the next `start`.
- `converged` out 1: the last completed pass made no relaxation.
- `neg_cycle` out 1: a negative cycle was detected.
- `neg_vertex` out PRED_W: destination j of the first relaxable edge found in the detection pass.
- `pass_count` out PRED_W+1: number of passes completed.

## Operation
- All RAMs are synchronous with 1-cycle read latency. A write is visible to a read issued in the following cycle.
- INF = 2^(WEIGHT_W-1)-1 and MIN = -2^(WEIGHT_W-1).
- State machine states: IDLE, INIT, READ, WAIT, RELAX, PASS_END, DONE.
- IDLE: on `start`, latch `src`, clear all status outputs, set `busy`, set k=0, and go to INIT.
- INIT: each cycle writes port A at address k.
  - Written word is {src, 0} if k==src, otherwise {0, INF}.
  - After k=NODES-1, go to READ with i=j=0, pass=0, and the relax flag cleared.
- READ: drive addresses i and j to both RAMs, then go to WAIT.
- WAIT: hold the addresses, then go to RELAX.
- RELAX: compute sum = sat(svw + e), the sum saturated to [MIN, INF-1].
  - An edge relaxes iff e≠0, svw≠INF and sum < dvw.
  - On relax: write port B with {i, sum} and set the relax flag.
  - Then advance j, and on wrap to 0 advance i. The next state is READ, or PASS_END after edge (NODES-1, NODES-1).
- PASS_END: increment `pass_count`.
  - If the relax flag is clear: `converged`=1, go to DONE.
  - Else if `pass_count` (new value) < NODES-1: clear the flag and go to READ.
  - Else: run the detection pass (see Configuration) or go to DONE.
- Detection pass: same READ/WAIT/RELAX sweep, but `vertmat_we_b` is never asserted.
  - The first edge satisfying the relax condition sets `neg_cycle`=1 and `neg_vertex`=j, then goes straight to DONE.
  - A full sweep with no such edge goes to DONE with `neg_cycle`=0.
  - The detection pass is not counted in `pass_count`.
- DONE: `busy`=0 and `done`=1. Go to IDLE the same cycle. Outputs hold until the next `start`.
- Self-loops (i==j) are processed like any other edge.

## Timing
- Reset values: state IDLE; `busy`, `done`, `converged` and `neg_cycle` all 0; `neg_vertex`=0; `pass_count`=0; all write enables 0; all addresses 0; all write data 0.
- Asserting `reset` mid-run aborts the run immediately. Vertex RAM contents are left partial.
- `start` to first INIT write: 1 cycle.
- INIT takes NODES cycles.
- Each pass takes 3·NODES²+1 cycles (PASS_END included).
- `done` rises 1 cycle after the final PASS_END or detection hit.
- A `start` that coincides with `done` is accepted and clears `done` on the next cycle.

## Configuration
- `BELLMAN_NEGCYCLE_EN` defined: the detection pass is compiled in and runs after NODES-1 passes that all relaxed.
- `BELLMAN_NEGCYCLE_EN` undefined: after NODES-1 passes the engine goes directly to DONE. `neg_cycle` and `neg_vertex` are tied to 0.

## Test plan
- **Convergence.** NODES=4, src=0, edges 0→1=5, 0→2=4, 1→2=-2. Required result: dist {0,5,3,INF}, pred[2]=1, `converged`=1, `pass_count`=2, `neg_cycle`=0.
- **Negative cycle, macro defined.** Edges 0→1=5, 1→2=-3, 2→1=1. Required result: `pass_count`=3, dist[1]=-1, dist[2]=-2, `neg_cycle`=1, `neg_vertex`=2.
- **Negative cycle, macro undefined.** Same graph as the previous scenario. Required result: `done` after 3 passes, `converged`=0, `neg_cycle`=0.
- **Saturation.** WEIGHT_W=8, edges 0→1=-128, 1→2=-1. Required result: dist[1]=-128 and dist[2]=-128 (not +127).
- **Unreachable source.** src=3, edge 0→1=1 only. Required result: dist[1] stays INF, `converged` after pass 1, no port-B writes.
- **Reset and timing.** Assert `reset` mid-pass-2: all outputs return to reset values. A later `start` then completes normally, with `done` exactly NODES+pass_count·(3·NODES²+1)+1 cycles after `start`.

Source files
------------

// File: rtl/bellman_ford_engine_if.sv
// Bus between the Bellman-Ford engine, its host control and the adjacency/vertex RAMs.
// master = engine side, slave = host/RAM side.
interface bellman_ford_engine_if #(
   parameter int NODES    = 16,
   parameter int WEIGHT_W = 32,
   parameter int PRED_W   = $clog2(NODES)
);
   logic                        start;
   logic [PRED_W-1:0]           src;
   logic [PRED_W-1:0]           adjmat_row_addr;
   logic [PRED_W-1:0]           adjmat_col_addr;
   logic signed [WEIGHT_W-1:0]  adjmat_q;
   logic [PRED_W-1:0]           vertmat_addr_a;
   logic [PRED_W-1:0]           vertmat_addr_b;
   logic [PRED_W+WEIGHT_W-1:0]  vertmat_q_a;
   logic [PRED_W+WEIGHT_W-1:0]  vertmat_q_b;
   logic [PRED_W+WEIGHT_W-1:0]  vertmat_data_a;
   logic [PRED_W+WEIGHT_W-1:0]  vertmat_data_b;
   logic                        vertmat_we_a;
   logic                        vertmat_we_b;
   logic                        busy;
   logic                        done;
   logic                        converged;
   logic                        neg_cycle;
   logic [PRED_W-1:0]           neg_vertex;
   logic [PRED_W:0]             pass_count;

   modport master (
      input  start, src, adjmat_q, vertmat_q_a, vertmat_q_b,
      output adjmat_row_addr, adjmat_col_addr,
      output vertmat_addr_a, vertmat_addr_b, vertmat_data_a, vertmat_data_b,
      output vertmat_we_a, vertmat_we_b,
      output busy, done, converged, neg_cycle, neg_vertex, pass_count
   );

   modport slave (
      output start, src, adjmat_q, vertmat_q_a, vertmat_q_b,
      input  adjmat_row_addr, adjmat_col_addr,
      input  vertmat_addr_a, vertmat_addr_b, vertmat_data_a, vertmat_data_b,
      input  vertmat_we_a, vertmat_we_b,
      input  busy, done, converged, neg_cycle, neg_vertex, pass_count
   );
endinterface

// File: rtl/bellman_ford_engine.sv
// Bellman-Ford relaxation engine over a dense adjacency RAM and a dual-port {pred, dist} vertex RAM.
// Optional negative-cycle detection pass is compiled in with `define BELLMAN_NEGCYCLE_EN.
//
// state    | meaning
// IDLE     | waiting for start
// INIT     | writing initial vertex word k through port A
// READ     | issuing edge (i,j) and vertex i/j reads
// WAIT     | holding addresses while RAM data arrives
// RELAX    | evaluating edge (i,j); port-B write on relax
// PASS_END | pass bookkeeping, decide next pass / detection / done
// DONE     | one-cycle completion state, back to IDLE
module bellman_ford_engine #(
   parameter int NODES    = 16,
   parameter int WEIGHT_W = 32,
   parameter int PRED_W   = $clog2(NODES)
) (
   input logic                   clk,
   input logic                   reset,
   bellman_ford_engine_if.master bus
);
   localparam int VW = PRED_W + WEIGHT_W;
   localparam logic signed [WEIGHT_W-1:0] INF    = {1'b0, {(WEIGHT_W-1){1'b1}}};
   localparam logic signed [WEIGHT_W:0]   SUM_HI = {2'b00, {(WEIGHT_W-2){1'b1}}, 1'b0};
   localparam logic signed [WEIGHT_W:0]   SUM_LO = {2'b11, {(WEIGHT_W-1){1'b0}}};
   localparam logic [PRED_W-1:0]          LAST      = PRED_W'(NODES-1);
   localparam logic [PRED_W:0]            LAST_PASS = (PRED_W+1)'(NODES-1);
`ifdef BELLMAN_NEGCYCLE_EN
   localparam logic DET_EN = 1'b1;
`else
   localparam logic DET_EN = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, INIT, READ, WAIT, RELAX, PASS_END, DONE} state_t;
   state_t state, state_nx;

   logic [PRED_W-1:0]          src_r, k, i, j;
   logic                       relax_flag, det_pass;
   logic                       busy_r, done_r, converged_r;
   logic [PRED_W:0]            pass_count_r, pass_nx;
   logic signed [WEIGHT_W-1:0] e, svw, dvw, sum_sat;
   logic signed [WEIGHT_W:0]   sum_wide;
   logic                       relax_ok, last_edge;
   logic                       unused_pred;

   assign e         = bus.adjmat_q;
   assign svw       = bus.vertmat_q_a[WEIGHT_W-1:0];
   assign dvw       = bus.vertmat_q_b[WEIGHT_W-1:0];
   assign sum_wide  = {svw[WEIGHT_W-1], svw} + {e[WEIGHT_W-1], e};
   assign pass_nx   = pass_count_r + 1'b1;
   assign last_edge = (i == LAST) && (j == LAST);
   assign unused_pred = ^{bus.vertmat_q_a[VW-1:WEIGHT_W], bus.vertmat_q_b[VW-1:WEIGHT_W]};

   // Upper clamp is INF-1 so a saturated path never reads back as "unreached".
   always_comb begin
      if (sum_wide > SUM_HI)      sum_sat = SUM_HI[WEIGHT_W-1:0];
      else if (sum_wide < SUM_LO) sum_sat = SUM_LO[WEIGHT_W-1:0];
      else                        sum_sat = sum_wide[WEIGHT_W-1:0];
   end

   assign relax_ok = (e != '0) && (svw != INF) && (sum_sat < dvw);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx            = state;
      bus.adjmat_row_addr = '0;
      bus.adjmat_col_addr = '0;
      bus.vertmat_addr_a  = '0;
      bus.vertmat_addr_b  = '0;
      bus.vertmat_data_a  = '0;
      bus.vertmat_data_b  = '0;
      bus.vertmat_we_a    = 1'b0;
      bus.vertmat_we_b    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) state_nx = INIT;
         end
         INIT: begin
            bus.vertmat_addr_a = k;
            bus.vertmat_we_a   = 1'b1;
            bus.vertmat_data_a = (k == src_r) ? {src_r, {WEIGHT_W{1'b0}}}
                                              : {{PRED_W{1'b0}}, INF};
            if (k == LAST) state_nx = READ;
         end
         READ, WAIT, RELAX: begin
            bus.adjmat_row_addr = i;
            bus.adjmat_col_addr = j;
            bus.vertmat_addr_a  = i;
            bus.vertmat_addr_b  = j;
            if (state == READ) begin
               state_nx = WAIT;
            end else if (state == WAIT) begin
               state_nx = RELAX;
            end else begin
               if (relax_ok && !det_pass) begin
                  bus.vertmat_we_b   = 1'b1;
                  bus.vertmat_data_b = {i, sum_sat};
               end
               if (det_pass && relax_ok) state_nx = DONE;
               else if (last_edge)       state_nx = det_pass ? DONE : PASS_END;
               else                      state_nx = READ;
            end
         end
         PASS_END: begin
            if (!relax_flag)              state_nx = DONE;
            else if (pass_nx < LAST_PASS) state_nx = READ;
            else                          state_nx = DET_EN ? READ : DONE;
         end
         DONE: begin
            state_nx = bus.start ? INIT : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         src_r        <= '0;
         k            <= '0;
         i            <= '0;
         j            <= '0;
         relax_flag   <= 1'b0;
         det_pass     <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         converged_r  <= 1'b0;
         pass_count_r <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  src_r        <= bus.src;
                  k            <= '0;
                  busy_r       <= 1'b1;
                  done_r       <= 1'b0;
                  converged_r  <= 1'b0;
                  pass_count_r <= '0;
               end
            end
            INIT: begin
               k          <= k + 1'b1;
               i          <= '0;
               j          <= '0;
               relax_flag <= 1'b0;
               det_pass   <= 1'b0;
            end
            RELAX: begin
               if (relax_ok) relax_flag <= 1'b1;
               if (j == LAST) begin
                  j <= '0;
                  i <= (i == LAST) ? '0 : i + 1'b1;
               end else begin
                  j <= j + 1'b1;
               end
            end
            PASS_END: begin
               pass_count_r <= pass_nx;
               relax_flag   <= 1'b0;
               if (!relax_flag) converged_r <= 1'b1;
               else if (pass_nx >= LAST_PASS) det_pass <= DET_EN;
            end
            default: ;
         endcase
         // Every path into DONE ends the run, so busy/done flip here once.
         if (state_nx == DONE) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
         end
      end
   end

`ifdef BELLMAN_NEGCYCLE_EN
   logic              neg_cycle_r;
   logic [PRED_W-1:0] neg_vertex_r;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         neg_cycle_r  <= 1'b0;
         neg_vertex_r <= '0;
      end else if ((state == IDLE || state == DONE) && bus.start) begin
         neg_cycle_r  <= 1'b0;
         neg_vertex_r <= '0;
      end else if (state == RELAX && det_pass && relax_ok) begin
         neg_cycle_r  <= 1'b1;
         neg_vertex_r <= j;
      end
   end

   assign bus.neg_cycle  = neg_cycle_r;
   assign bus.neg_vertex = neg_vertex_r;
`else
   assign bus.neg_cycle  = 1'b0;
   assign bus.neg_vertex = '0;
`endif

   assign bus.busy       = busy_r;
   assign bus.done       = done_r;
   assign bus.converged  = converged_r;
   assign bus.pass_count = pass_count_r;
endmodule

// File: tb/tb_bellman_ford_engine.sv
// Bench for bellman_ford_engine: directed vector table, saturation and reset sequences,
// plus random graphs checked against a pass-by-pass Bellman-Ford reference model.
module tb_bellman_ford_engine;
   localparam int N  = 4;
   localparam int P  = 2;
   localparam int W  = 32;
   localparam int W8 = 8;
   localparam int T  = 3*N*N + 1;
   localparam longint INF32 = 64'sd2147483647;
`ifdef BELLMAN_NEGCYCLE_EN
   localparam bit NEG_EN = 1'b1;
`else
   localparam bit NEG_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   bellman_ford_engine_if #(.NODES(N), .WEIGHT_W(W))  bus  ();
   bellman_ford_engine_if #(.NODES(N), .WEIGHT_W(W8)) bus8 ();

   bellman_ford_engine #(.NODES(N), .WEIGHT_W(W))  dut  (.clk(clk), .reset(reset), .bus(bus));
   bellman_ford_engine #(.NODES(N), .WEIGHT_W(W8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

   logic signed [W-1:0]  adj  [N][N];
   logic signed [W8-1:0] adj8 [N][N];
   logic [P+W-1:0]       vmem  [N];
   logic [P+W8-1:0]      vmem8 [N];
   longint               g [N][N];
   int                   we_b_total = 0;

   always @(posedge clk) begin
      bus.adjmat_q    <= adj[bus.adjmat_row_addr][bus.adjmat_col_addr];
      bus.vertmat_q_a <= vmem[bus.vertmat_addr_a];
      bus.vertmat_q_b <= vmem[bus.vertmat_addr_b];
      if (bus.vertmat_we_a) vmem[bus.vertmat_addr_a] <= bus.vertmat_data_a;
      if (bus.vertmat_we_b) begin
         vmem[bus.vertmat_addr_b] <= bus.vertmat_data_b;
         we_b_total <= we_b_total + 1;
      end
   end

   always @(posedge clk) begin
      bus8.adjmat_q    <= adj8[bus8.adjmat_row_addr][bus8.adjmat_col_addr];
      bus8.vertmat_q_a <= vmem8[bus8.vertmat_addr_a];
      bus8.vertmat_q_b <= vmem8[bus8.vertmat_addr_b];
      if (bus8.vertmat_we_a) vmem8[bus8.vertmat_addr_a] <= bus8.vertmat_data_a;
      if (bus8.vertmat_we_b) vmem8[bus8.vertmat_addr_b] <= bus8.vertmat_data_b;
   end

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic longint dist_of(input int v);
      logic signed [W-1:0] d;
      d = vmem[v][W-1:0];
      return d;
   endfunction

   function automatic longint dist8_of(input int v);
      logic signed [W8-1:0] d;
      d = vmem8[v][W8-1:0];
      return d;
   endfunction

   function automatic int pred_of(input int v);
      return int'(vmem[v][P+W-1:W]);
   endfunction

   task automatic clear_graph();
      for (int a = 0; a < N; a++)
         for (int b = 0; b < N; b++) begin
            adj[a][b]  = '0;
            adj8[a][b] = '0;
            g[a][b]    = 0;
         end
   endtask

   task automatic add_edge(input int a, input int b, input longint w);
      adj[a][b]  = W'(w);
      adj8[a][b] = W8'(w);
      g[a][b]    = w;
   endtask

   // Pulse start and count cycles until done; done is expected on cycle cyc after the start cycle.
   task automatic run(input bit narrow, input int s, output int cyc);
      @(negedge clk);
      if (narrow) begin bus8.src = P'(s); bus8.start = 1'b1; end
      else        begin bus.src  = P'(s); bus.start  = 1'b1; end
      @(negedge clk);
      bus.start  = 1'b0;
      bus8.start = 1'b0;
      cyc = 1;
      while (!(narrow ? bus8.done : bus.done) && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      tests++;
      if (!(narrow ? bus8.done : bus.done)) begin
         fails++;
         $display("FAIL done_timeout: done still low after %0d cycles, expected high", cyc);
      end
   endtask

   // Reference model: textbook sweep of all (i,j) in row-major order with in-place updates.
   longint m_dist [N];
   int     m_pred [N];
   int     m_passes, m_negv, m_cyc, m_writes;
   bit     m_conv, m_neg;

   function automatic bit relaxes(input int a, input int b, input longint inf, input longint mn,
                                  output longint sum);
      sum = m_dist[a] + g[a][b];
      if (sum > inf - 1) sum = inf - 1;
      if (sum < mn)      sum = mn;
      return (g[a][b] != 0) && (m_dist[a] != inf) && (sum < m_dist[b]);
   endfunction

   task automatic model(input int s, input int w);
      longint inf, mn, sum;
      bit     changed, hit;
      int     cnt;
      inf = (longint'(1) << (w-1)) - 1;
      mn  = -(longint'(1) << (w-1));
      for (int v = 0; v < N; v++) begin
         m_dist[v] = (v == s) ? 0 : inf;
         m_pred[v] = (v == s) ? s : 0;
      end
      m_passes = 0; m_conv = 0; m_neg = 0; m_negv = 0; m_writes = 0;
      m_cyc = N + 1;
      for (int p = 0; p < N-1 && !m_conv; p++) begin
         changed = 0;
         for (int a = 0; a < N; a++)
            for (int b = 0; b < N; b++)
               if (relaxes(a, b, inf, mn, sum)) begin
                  m_dist[b] = sum;
                  m_pred[b] = a;
                  changed   = 1;
                  m_writes++;
               end
         m_passes++;
         m_cyc += T;
         if (!changed) m_conv = 1;
      end
      if (NEG_EN && !m_conv) begin
         hit = 0;
         cnt = 0;
         for (int a = 0; a < N; a++)
            for (int b = 0; b < N; b++)
               if (!hit) begin
                  cnt++;
                  if (relaxes(a, b, inf, mn, sum)) begin
                     hit    = 1;
                     m_negv = b;
                  end
               end
         m_neg = hit;
         m_cyc += 3*cnt;
      end
   endtask

   typedef struct packed { int fr; int to; int w; } edge_t;
   typedef struct {
      int     src;
      edge_t  e0, e1, e2;
      longint d0, d1, d2, d3;
      int     pv, pexp;
      bit     conv;
      int     passes;
      bit     neg;
      int     negv, cyc, writes;
   } vec_t;

   vec_t vecs [3];

   initial begin
      int cyc, w0, s;
      int wt;
      bus.start  = 1'b0; bus.src  = '0;
      bus8.start = 1'b0; bus8.src = '0;
      clear_graph();
      repeat (3) @(negedge clk);

      chk("reset busy",       bus.busy, 0);
      chk("reset done",       bus.done, 0);
      chk("reset converged",  bus.converged, 0);
      chk("reset neg_cycle",  bus.neg_cycle, 0);
      chk("reset pass_count", bus.pass_count, 0);
      chk("reset we",         {bus.vertmat_we_a, bus.vertmat_we_b}, 0);
      reset = 1'b0;

      vecs[0] = '{0, '{0,1,5}, '{0,2,4}, '{1,2,-2}, 0, 5, 3, INF32,
                  2, 1, 1'b1, 2, 1'b0, 0, N + 2*T + 1, 3};
      vecs[1] = '{0, '{0,1,5}, '{1,2,-3}, '{2,1,1}, 0, -1, -2, INF32,
                  1, 2, 1'b0, 3, NEG_EN, NEG_EN ? 2 : 0,
                  N + 3*T + 1 + (NEG_EN ? 21 : 0), 7};
      vecs[2] = '{3, '{0,1,1}, '{0,0,0}, '{0,0,0}, INF32, INF32, INF32, 0,
                  3, 3, 1'b1, 1, 1'b0, 0, N + T + 1, 0};

      for (int t = 0; t < 3; t++) begin
         clear_graph();
         add_edge(vecs[t].e0.fr, vecs[t].e0.to, vecs[t].e0.w);
         add_edge(vecs[t].e1.fr, vecs[t].e1.to, vecs[t].e1.w);
         add_edge(vecs[t].e2.fr, vecs[t].e2.to, vecs[t].e2.w);
         w0 = we_b_total;
         run(1'b0, vecs[t].src, cyc);
         chk($sformatf("vec%0d dist0", t), dist_of(0), vecs[t].d0);
         chk($sformatf("vec%0d dist1", t), dist_of(1), vecs[t].d1);
         chk($sformatf("vec%0d dist2", t), dist_of(2), vecs[t].d2);
         chk($sformatf("vec%0d dist3", t), dist_of(3), vecs[t].d3);
         chk($sformatf("vec%0d pred", t), pred_of(vecs[t].pv), vecs[t].pexp);
         chk($sformatf("vec%0d converged", t), bus.converged, vecs[t].conv);
         chk($sformatf("vec%0d pass_count", t), bus.pass_count, vecs[t].passes);
         chk($sformatf("vec%0d neg_cycle", t), bus.neg_cycle, vecs[t].neg);
         chk($sformatf("vec%0d neg_vertex", t), bus.neg_vertex, vecs[t].negv);
         chk($sformatf("vec%0d latency", t), cyc, vecs[t].cyc);
         chk($sformatf("vec%0d portb_writes", t), we_b_total - w0, vecs[t].writes);
         chk($sformatf("vec%0d busy", t), bus.busy, 0);
      end

      // Narrow weights: the chain must pin at MIN instead of wrapping positive.
      clear_graph();
      add_edge(0, 1, -128);
      add_edge(1, 2, -1);
      run(1'b1, 0, cyc);
      chk("sat dist1",      dist8_of(1), -128);
      chk("sat dist2",      dist8_of(2), -128);
      chk("sat dist3",      dist8_of(3), 127);
      chk("sat converged",  bus8.converged, 1);
      chk("sat pass_count", bus8.pass_count, 2);

      for (int r = 0; r < 20; r++) begin
         clear_graph();
         for (int a = 0; a < N; a++)
            for (int b = 0; b < N; b++)
               if ($urandom_range(0, 99) < 35) begin
                  wt = int'($urandom_range(0, 12)) - 3;
                  add_edge(a, b, wt);
               end
         s = int'($urandom_range(0, N-1));
         model(s, W);
         w0 = we_b_total;
         run(1'b0, s, cyc);
         for (int v = 0; v < N; v++) begin
            chk($sformatf("rnd%0d dist%0d", r, v), dist_of(v), m_dist[v]);
            chk($sformatf("rnd%0d pred%0d", r, v), pred_of(v), m_pred[v]);
         end
         chk($sformatf("rnd%0d converged", r),  bus.converged, m_conv);
         chk($sformatf("rnd%0d pass_count", r), bus.pass_count, m_passes);
         chk($sformatf("rnd%0d neg_cycle", r),  bus.neg_cycle, m_neg);
         chk($sformatf("rnd%0d neg_vertex", r), bus.neg_vertex, m_negv);
         chk($sformatf("rnd%0d latency", r),    cyc, m_cyc);
         chk($sformatf("rnd%0d portb_writes", r), we_b_total - w0, m_writes);
      end

      // Abort in the middle of pass 2, then a clean run must still time correctly.
      clear_graph();
      add_edge(0, 1, 5);
      add_edge(1, 2, -3);
      add_edge(2, 1, 1);
      @(negedge clk);
      bus.src = '0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 0;
      while (bus.pass_count != 1 && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      repeat (20) @(negedge clk);
      chk("abort in pass2 pass_count", bus.pass_count, 1);
      chk("abort in pass2 busy",       bus.busy, 1);
      reset = 1'b1;
      #1;
      chk("abort busy",       bus.busy, 0);
      chk("abort done",       bus.done, 0);
      chk("abort converged",  bus.converged, 0);
      chk("abort neg_cycle",  bus.neg_cycle, 0);
      chk("abort neg_vertex", bus.neg_vertex, 0);
      chk("abort pass_count", bus.pass_count, 0);
      chk("abort we",         {bus.vertmat_we_a, bus.vertmat_we_b}, 0);
      chk("abort addr",       {bus.vertmat_addr_a, bus.vertmat_addr_b,
                               bus.adjmat_row_addr, bus.adjmat_col_addr}, 0);
      chk("abort data_a",     bus.vertmat_data_a, 0);
      chk("abort data_b",     bus.vertmat_data_b, 0);
      @(negedge clk);
      reset = 1'b0;

      clear_graph();
      add_edge(0, 1, 5);
      add_edge(0, 2, 4);
      add_edge(1, 2, -2);
      run(1'b0, 0, cyc);
      chk("post_abort latency",    cyc, N + 2*T + 1);
      chk("post_abort pass_count", bus.pass_count, 2);
      chk("post_abort converged",  bus.converged, 1);
      chk("post_abort dist2",      dist_of(2), 3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
